// File: rtl/rr_burst_arbiter.sv
// N-master round-robin arbiter with per-request burst length, slave backpressure and
// abort on request withdrawal, feeding a single downstream slave port.
module rr_burst_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 4,
   localparam int unsigned SRC_W = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N*LEN_W-1:0]    len,
   input  logic [N*DATA_W-1:0]   data,
   output logic [N-1:0]          gnt,
   output logic                  s_valid,
   output logic [DATA_W-1:0]     s_data,
   output logic [SRC_W-1:0]      s_src,
   output logic                  s_last,
   input  logic                  s_rdy,
   output logic                  busy
);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e             state_q, state_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [SRC_W-1:0]   ptr_q, ptr_d;
   logic [LEN_W-1:0]   beats_q, beats_d;
   logic [N-1:0]       gnt_q, gnt_d;

   logic [SRC_W-1:0]   pick;
   logic               pick_found;
   logic [SRC_W-1:0]   cand_idx;
   int unsigned        cand;
   logic [SRC_W-1:0]   src_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         src_q   <= '0;
         ptr_q   <= '0;
         beats_q <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
         beats_q <= beats_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      // First requester at or above ptr, wrapping modulo N.
      pick       = '0;
      pick_found = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand     = (32'(ptr_q) + k) % N;
         cand_idx = SRC_W'(cand);
         if (!pick_found && req[cand_idx]) begin
            pick       = cand_idx;
            pick_found = 1'b1;
         end
      end

      src_inc = (src_q == SRC_W'(N - 1)) ? '0 : src_q + 1'b1;

      state_d = state_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      beats_d = beats_q;
      gnt_d   = gnt_q;

      unique case (state_q)
         StIdle: begin
            gnt_d = '0;
            if (pick_found) begin
               state_d = StBurst;
               src_d   = pick;
               beats_d = len[pick*LEN_W +: LEN_W];
               gnt_d   = N'(1) << pick;
            end
         end
         StBurst: begin
            if (!req[src_q]) begin
               state_d = StIdle;
               gnt_d   = '0;
               ptr_d   = src_inc;
            end else if (s_rdy) begin
               if (beats_q == '0) begin
                  state_d = StIdle;
                  gnt_d   = '0;
                  ptr_d   = src_inc;
               end else begin
                  beats_d = beats_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy    = (state_q == StBurst);
      gnt     = gnt_q;
      s_src   = src_q;
      s_valid = busy && req[src_q];
      s_last  = s_valid && (beats_q == '0);
      // Data is muxed live from the granted master, not registered.
      s_data  = data[src_q*DATA_W +: DATA_W];
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a transaction-level model counting beats sent per burst.
module tb_rr_burst_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int LW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N*LW-1:0]   len;
   logic [N*DW-1:0]   data;
   logic [N-1:0]      gnt;
   logic              s_valid;
   logic [DW-1:0]     s_data;
   logic [1:0]        s_src;
   logic              s_last;
   logic              s_rdy;
   logic              busy;

   rr_burst_arbiter #(.N(N), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .req(req), .len(len), .data(data), .gnt(gnt),
      .s_valid(s_valid), .s_data(s_data), .s_src(s_src), .s_last(s_last),
      .s_rdy(s_rdy), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: owner, beats sent so far, beats in the burst, round-robin start.
   bit m_busy;
   int m_owner, m_sent, m_total, m_ptr;

   int acc_beats, last_count, last_at, busy_cycles;
   logic [N-1:0] prev_gnt;
   int obs_grants[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      acc_beats   = 0;
      last_count  = 0;
      last_at     = 0;
      busy_cycles = 0;
      obs_grants.delete();
   endtask

   task automatic model_edge();
      bit found;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_sent = 0; m_total = 1; m_ptr = 0;
      end else if (!m_busy) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               found   = 1;
               m_owner = (m_ptr + k) % N;
               m_total = int'(len[m_owner*LW +: LW]) + 1;
               m_sent  = 0;
               m_busy  = 1;
            end
         end
      end else if (!req[m_owner]) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % N;
      end else if (s_rdy) begin
         m_sent++;
         if (m_sent == m_total) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
         end
      end
   endtask

   // One clock: randomise data, compare outputs with the model, then advance both.
   task automatic step();
      bit exp_valid;
      data = {$urandom, $urandom};
      #1;
      exp_valid = m_busy && req[m_owner];
      check("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
      check("busy", 32'(busy), 32'(m_busy));
      check("s_valid", 32'(s_valid), 32'(exp_valid));
      check("s_last", 32'(s_last), 32'(exp_valid && (m_sent == m_total - 1)));
      check("s_src", 32'(s_src), 32'(m_owner));
      if (exp_valid) check("s_data", 32'(s_data), 32'(data[m_owner*DW +: DW]));
      if (busy) busy_cycles++;
      if (s_valid && s_rdy) begin
         acc_beats++;
         if (s_last) begin
            last_count++;
            last_at = acc_beats;
         end
      end
      if (gnt != 0 && prev_gnt == 0) begin
         for (int i = 0; i < N; i++) if (gnt[i]) obs_grants.push_back(i);
      end
      prev_gnt = gnt;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      rst = 1'b0;
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_valid", 32'(s_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req = '0; len = '0; data = '0; s_rdy = 1'b0;
      prev_gnt = '0;
      @(posedge clk);
      #1;
      m_busy = 0; m_owner = 0; m_sent = 0; m_total = 1; m_ptr = 0;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_src", 32'(s_src), 32'd0);
      check("rst_last", 32'(s_last), 32'd0);
      rst = 1'b0;

      // Single master, 4-beat burst.
      clear_stats();
      req = 4'b0100; len = '0; len[2*LW +: LW] = 4'd3; s_rdy = 1'b1;
      step();
      check("single_gnt", 32'(gnt), 32'h4);
      repeat (4) step();
      check("single_beats", acc_beats, 4);
      check("single_last_cnt", last_count, 1);
      check("single_last_at", last_at, 4);
      check("single_gnt_off", 32'(gnt), 32'd0);
      req = '0;
      step();

      // Fairness from reset with all masters requesting single beats.
      do_reset();
      clear_stats();
      req = 4'b1111; len = '0; s_rdy = 1'b1;
      repeat (10) step();
      check("fair_count", obs_grants.size() >= 5, 1);
      if (obs_grants.size() >= 5) begin
         check("fair_0", obs_grants[0], 0);
         check("fair_1", obs_grants[1], 1);
         check("fair_2", obs_grants[2], 2);
         check("fair_3", obs_grants[3], 3);
         check("fair_4", obs_grants[4], 0);
      end

      // Backpressure: 2-beat burst with ready pattern 1,0,0,1.
      do_reset();
      req = 4'b0001; len = '0; len[0 +: LW] = 4'd1; s_rdy = 1'b1;
      step();
      clear_stats();
      s_rdy = 1'b1; step();
      s_rdy = 1'b0; step();
      s_rdy = 1'b0; step();
      s_rdy = 1'b1; step();
      check("bp_beats", acc_beats, 2);
      check("bp_busy_cycles", busy_cycles, 4);
      check("bp_last_at", last_at, 2);
      check("bp_idle_gnt", 32'(gnt), 32'd0);

      // Abort: master 1 drops req after 3 beats; master 2 waiting gets the next grant.
      do_reset();
      req = 4'b0110; len = '0; len[1*LW +: LW] = 4'd7; s_rdy = 1'b1;
      step();
      check("abort_gnt1", 32'(gnt), 32'h2);
      clear_stats();
      repeat (3) step();
      req = 4'b0100;
      step();
      check("abort_beats", acc_beats, 3);
      check("abort_no_last", last_count, 0);
      check("abort_idle_gnt", 32'(gnt), 32'd0);
      step();
      check("abort_next_gnt", 32'(gnt), 32'h4);
      req = '0;
      step();

      // Reset mid-burst after the pointer has moved past master 1.
      do_reset();
      req = 4'b0010; len = '0; s_rdy = 1'b1;
      repeat (2) step();
      req = 4'b0100; len[2*LW +: LW] = 4'd4;
      repeat (3) step();
      clear_stats();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_gnt", 32'(gnt), 32'd0);
      check("mid_rst_valid", 32'(s_valid), 32'd0);
      check("mid_rst_no_last", last_count, 0);
      req = 4'b1001;
      step();
      check("mid_rst_first", 32'(gnt), 32'h1);
      req = '0;
      repeat (2) step();

      // Maximum length burst.
      do_reset();
      req = 4'b0001; len = '0; len[0 +: LW] = 4'hF; s_rdy = 1'b1;
      step();
      clear_stats();
      repeat (16) step();
      check("max_beats", acc_beats, 16);
      check("max_last_cnt", last_count, 1);
      check("max_last_at", last_at, 16);
      check("max_idle", 32'(busy), 32'd0);
      req = '0;
      step();

      // Random traffic: requests mostly held, occasional withdrawals and resets.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
         end
         len   = {$urandom, $urandom};
         s_rdy = ($urandom_range(0, 3) != 0);
         rst   = ($urandom_range(0, 79) == 0);
         step();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "bench timeout");
   end
endmodule
